// File: rtl/pipeline_pkg.sv
// +----------------------------------------------------------------------------+
// | pipeline_pkg                                                               |
// | Shared pipeline constants: instruction width, bubble encoding, opcodes.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package pipeline_pkg;

    localparam int INSTR_W = 32;

    localparam int OPCODE_LSB = 2;
    localparam int OPCODE_W   = 5;

    localparam logic [OPCODE_W-1:0] OP_LOAD   = 5'b00000;
    localparam logic [OPCODE_W-1:0] OP_OPIMM  = 5'b00100;
    localparam logic [OPCODE_W-1:0] OP_STORE  = 5'b01000;
    localparam logic [OPCODE_W-1:0] OP_OP     = 5'b01100;
    localparam logic [OPCODE_W-1:0] OP_BRANCH = 5'b11000;
    localparam logic [OPCODE_W-1:0] OP_JAL    = 5'b11011;
    // Decodes to the control unit's default: no writes, no branch, no jump.
    localparam logic [OPCODE_W-1:0] OP_BUBBLE = 5'b11111;

    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_007F;

    typedef enum logic [1:0] {
        NPC_SEQ    = 2'd0,
        NPC_HOLD   = 2'd1,
        NPC_TARGET = 2'd2
    } npc_sel_e;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic               valid;
    } ifid_word_t;

    function automatic logic [OPCODE_W-1:0] opcode_of(input logic [INSTR_W-1:0] instr);
        return instr[OPCODE_LSB +: OPCODE_W];
    endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_stage_if.sv
// +----------------------------------------------------------------------------+
// | fetch_stage_if                                                             |
// | Fetch-stage control, instruction-memory and IF/ID bundle.                  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

interface fetch_stage_if
    import pipeline_pkg::*;
#(
    parameter int PC_WIDTH  = 9,
    parameter int CNT_WIDTH = 16
);

    logic                 stall;
    logic                 redirect_valid;
    logic [PC_WIDTH-1:0]  redirect_target;
    logic [PC_WIDTH-1:0]  imem_addr;
    logic [INSTR_W-1:0]   imem_rdata;
    logic [INSTR_W-1:0]   ifid_instr;
    logic [PC_WIDTH-1:0]  ifid_pc;
    logic                 ifid_valid;
    logic [CNT_WIDTH-1:0] fetch_count;
    logic [CNT_WIDTH-1:0] bubble_count;

    modport slave (
        input  stall, redirect_valid, redirect_target, imem_rdata,
        output imem_addr, ifid_instr, ifid_pc, ifid_valid, fetch_count, bubble_count
    );

    modport master (
        output stall, redirect_valid, redirect_target, imem_rdata,
        input  imem_addr, ifid_instr, ifid_pc, ifid_valid, fetch_count, bubble_count
    );

endinterface

`default_nettype wire

// File: rtl/sat_counter.sv
// +----------------------------------------------------------------------------+
// | sat_counter                                                                |
// | Up-counter that sticks at all-ones instead of wrapping.                    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {WIDTH{1'b1}})) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

`default_nettype wire

// File: rtl/fetch_stage.sv
// +----------------------------------------------------------------------------+
// | fetch_stage                                                                |
// | Program counter, next-PC select and IF/ID register with debug counters.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module fetch_stage
    import pipeline_pkg::*;
#(
    parameter int PC_WIDTH  = 9,
    parameter int RESET_PC  = 0,
    parameter int CNT_WIDTH = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    fetch_stage_if.slave  bus
);

    localparam logic [PC_WIDTH-1:0] C_RESET_PC = PC_WIDTH'(RESET_PC);

    logic [PC_WIDTH-1:0] pc_q;
    logic [PC_WIDTH-1:0] pc_d;
    logic                prime_q;
    npc_sel_e            npc_sel;

    ifid_word_t          ifid_q;
    ifid_word_t          ifid_d;
    logic [PC_WIDTH-1:0] ifid_pc_q;
    logic [PC_WIDTH-1:0] ifid_pc_d;

    logic                fetch_inc;
    logic                bubble_inc;

    // Until the memory has been primed, imem_rdata does not belong to pc_q.
    always_comb begin
        npc_sel = NPC_SEQ;
        if (bus.redirect_valid) begin
            npc_sel = NPC_TARGET;
        end else if (!prime_q || bus.stall) begin
            npc_sel = NPC_HOLD;
        end
    end

    always_comb begin
        pc_d = pc_q + 1'b1;
        case (npc_sel)
            NPC_TARGET: pc_d = bus.redirect_target;
            NPC_HOLD:   pc_d = pc_q;
            default:    pc_d = pc_q + 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q    <= C_RESET_PC;
            prime_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            prime_q <= 1'b1;
        end
    end

    always_comb begin
        ifid_d     = ifid_q;
        ifid_pc_d  = ifid_pc_q;
        fetch_inc  = 1'b0;
        bubble_inc = 1'b0;
        if (bus.redirect_valid) begin
            ifid_d.instr = NOP_INSTR;
            ifid_d.valid = 1'b0;
            bubble_inc   = 1'b1;
        end else if (!bus.stall) begin
            ifid_d.instr = bus.imem_rdata;
            ifid_d.valid = prime_q;
            ifid_pc_d    = pc_q;
            fetch_inc    = prime_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ifid_q.instr <= NOP_INSTR;
            ifid_q.valid <= 1'b0;
            ifid_pc_q    <= '0;
        end else begin
            ifid_q       <= ifid_d;
            ifid_pc_q    <= ifid_pc_d;
        end
    end

    sat_counter #(.WIDTH(CNT_WIDTH)) u_fetch_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (fetch_inc),
        .count (bus.fetch_count)
    );

    sat_counter #(.WIDTH(CNT_WIDTH)) u_bubble_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (bubble_inc),
        .count (bus.bubble_count)
    );

    assign bus.imem_addr  = pc_d;
    assign bus.ifid_instr = ifid_q.instr;
    assign bus.ifid_valid = ifid_q.valid;
    assign bus.ifid_pc    = ifid_pc_q;

endmodule

`default_nettype wire

// File: tb/tb_fetch_stage.sv
// +----------------------------------------------------------------------------+
// | tb_fetch_stage                                                             |
// | Directed bench for fetch_stage; a 2-bit-counter copy covers saturation.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_fetch_stage;

    localparam logic [31:0] C_NOP  = 32'h0000_007F;
    localparam logic [31:0] C_BASE = 32'h1000_0000;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;

    fetch_stage_if #(.PC_WIDTH(9), .CNT_WIDTH(16)) bus ();
    fetch_stage_if #(.PC_WIDTH(9), .CNT_WIDTH(2))  sbus ();

    fetch_stage #(.PC_WIDTH(9), .RESET_PC(0), .CNT_WIDTH(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    fetch_stage #(.PC_WIDTH(9), .RESET_PC(0), .CNT_WIDTH(2)) dut_small (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (sbus)
    );

    assign sbus.stall           = bus.stall;
    assign sbus.redirect_valid  = bus.redirect_valid;
    assign sbus.redirect_target = bus.redirect_target;
    assign sbus.imem_rdata      = bus.imem_rdata;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous instruction memory: imem[i] = 0x1000_0000 + i.
    always @(posedge clk) begin
        bus.imem_rdata <= C_BASE + {23'd0, bus.imem_addr};
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_ifid(input string tag, input logic [31:0] instr,
                            input logic [8:0] pc, input logic valid);
        chk({tag, ".instr"}, bus.ifid_instr, instr);
        chk({tag, ".pc"},    {23'd0, bus.ifid_pc}, {23'd0, pc});
        chk({tag, ".valid"}, {31'd0, bus.ifid_valid}, {31'd0, valid});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        bus.stall = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_target = '0;

        step();
        step();
        chk_ifid("reset", C_NOP, 9'd0, 1'b0);
        chk("reset.addr", {23'd0, bus.imem_addr}, 32'd0);
        chk("reset.fcnt", {16'd0, bus.fetch_count}, 32'd0);
        chk("reset.bcnt", {16'd0, bus.bubble_count}, 32'd0);

        rst_n = 1'b1;
        step();                                   // edge 1: prime only
        chk("e1.valid", {31'd0, bus.ifid_valid}, 32'd0);
        chk("e1.addr", {23'd0, bus.imem_addr}, 32'd1);
        step();
        chk_ifid("e2", C_BASE + 32'd0, 9'd0, 1'b1);
        step();
        chk_ifid("e3", C_BASE + 32'd1, 9'd1, 1'b1);
        step();
        chk_ifid("e4", C_BASE + 32'd2, 9'd2, 1'b1);

        bus.stall = 1'b1;
        #1;
        chk("stall.addr0", {23'd0, bus.imem_addr}, 32'd3);
        for (int i = 0; i < 3; i++) begin
            step();
            chk_ifid("stall", C_BASE + 32'd2, 9'd2, 1'b1);
            chk("stall.addr", {23'd0, bus.imem_addr}, 32'd3);
        end
        bus.stall = 1'b0;
        step();
        chk_ifid("unstall", C_BASE + 32'd3, 9'd3, 1'b1);
        chk("unstall.fcnt", {16'd0, bus.fetch_count}, 32'd4);
        step();
        chk_ifid("seq4", C_BASE + 32'd4, 9'd4, 1'b1);

        bus.redirect_valid = 1'b1;
        bus.redirect_target = 9'h040;
        step();
        chk_ifid("redir.bubble", C_NOP, 9'd4, 1'b0);
        chk("redir.bcnt", {16'd0, bus.bubble_count}, 32'd1);
        bus.redirect_valid = 1'b0;
        step();
        chk_ifid("redir.tgt", C_BASE + 32'h40, 9'h040, 1'b1);
        step();
        chk_ifid("redir.tgt1", C_BASE + 32'h41, 9'h041, 1'b1);
        chk("redir.fcnt", {16'd0, bus.fetch_count}, 32'd7);

        bus.stall = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_target = 9'h010;
        step();
        chk_ifid("both.bubble", C_NOP, 9'h041, 1'b0);
        chk("both.bcnt", {16'd0, bus.bubble_count}, 32'd2);
        bus.stall = 1'b0;
        bus.redirect_valid = 1'b0;
        step();
        chk_ifid("both.tgt", C_BASE + 32'h10, 9'h010, 1'b1);

        bus.redirect_valid = 1'b1;
        bus.redirect_target = 9'h1FE;
        step();
        bus.redirect_valid = 1'b0;
        step();
        chk_ifid("wrap0", C_BASE + 32'h1FE, 9'h1FE, 1'b1);
        step();
        chk_ifid("wrap1", C_BASE + 32'h1FF, 9'h1FF, 1'b1);
        step();
        chk_ifid("wrap2", C_BASE + 32'h000, 9'h000, 1'b1);
        step();
        chk_ifid("wrap3", C_BASE + 32'h001, 9'h001, 1'b1);
        chk("wrap.fcnt", {16'd0, bus.fetch_count}, 32'd12);
        chk("sat.small3", {30'd0, sbus.bubble_count}, 32'd3);

        bus.redirect_valid = 1'b1;
        bus.redirect_target = 9'h020;
        step();
        bus.redirect_valid = 1'b0;
        chk("sat.bcnt", {16'd0, bus.bubble_count}, 32'd4);
        chk("sat.small", {30'd0, sbus.bubble_count}, 32'd3);
        chk("sat.smallf", {30'd0, sbus.fetch_count}, 32'd3);
        step();
        chk_ifid("pre_rst", C_BASE + 32'h20, 9'h020, 1'b1);

        #2 rst_n = 1'b0;
        #1;
        chk_ifid("async_rst", C_NOP, 9'd0, 1'b0);
        chk("async_rst.addr", {23'd0, bus.imem_addr}, 32'd0);
        chk("async_rst.fcnt", {16'd0, bus.fetch_count}, 32'd0);
        chk("async_rst.bcnt", {16'd0, bus.bubble_count}, 32'd0);
        #4 rst_n = 1'b1;
        step();
        chk("rst.e1.valid", {31'd0, bus.ifid_valid}, 32'd0);
        step();
        chk_ifid("rst.e2", C_BASE + 32'd0, 9'd0, 1'b1);
        step();
        chk_ifid("rst.e3", C_BASE + 32'd1, 9'd1, 1'b1);

        // Redirect while the memory is not yet primed after reset.
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_target = 9'h080;
        #1;
        chk("unprimed.addr", {23'd0, bus.imem_addr}, 32'h80);
        step();
        bus.redirect_valid = 1'b0;
        chk_ifid("unprimed.e1", C_NOP, 9'd0, 1'b0);
        chk("unprimed.bcnt", {16'd0, bus.bubble_count}, 32'd1);
        step();
        chk_ifid("unprimed.e2", C_BASE + 32'h80, 9'h080, 1'b1);
        chk("unprimed.fcnt", {16'd0, bus.fetch_count}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
